reg_file: RTL
=============

# reg_file

Parametrised multi-port register file, successor to the single 32-bit `Register`: `NUM_REGS` words of `DATA_W` bits, one byte-strobed write port and `NUM_RD` read ports. Optional write-to-read bypass, optional hardwired-zero register 0 and optional registered read outputs. Sits in the MIPS decode stage and serves rs/rt operand reads and writeback from the WB stage.

## Interface
- `DATA_W`, 32, word width in bits; must be a multiple of 8.
- `NUM_REGS`, 32, number of words; must be at least 2.
- `NUM_RD`, 2, number of read ports; must be at least 1.
- `ZERO_REG`, 1, 1 = word 0 reads as 0 and ignores writes.
- `BYPASS`, 1, 1 = same-cycle write data forwarded to matching read ports.
- `OUT_REG`, 0, 0 = combinational read; 1 = read data registered, one cycle latency.
- `ADDR_W` (localparam), `$clog2(NUM_REGS)`, address width.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `we`  in  1  write enable.
- `waddr`  in  ADDR_W  write address.
- `wstrb`  in  DATA_W/8  byte write strobes; bit i covers bits [8i+7:8i].
- `wdata`  in  DATA_W  write data.
- `raddr`  in  NUM_RD*ADDR_W  read addresses; port p is at slice [p*ADDR_W +: ADDR_W].
- `rdata`  out  NUM_RD*DATA_W  read data; port p is at slice [p*DATA_W +: DATA_W].

## Operation
- Storage: `NUM_REGS` x `DATA_W` flops. Every word is cleared to 0 on any rising edge where `reset`=1.
- Write:
  - A write commits on a rising edge when `reset`=0 and `we`=1.
  - Only the bytes with `wstrb[i]`=1 are updated; the other bytes keep their value.
  - `we`=1 with `wstrb`=0 is a no-op.
  - Addresses at or above `NUM_REGS` (non-power-of-2 depth) are ignored.
- Zero register (`ZERO_REG`=1):
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0 on every port, including the bypass path.
- Read: each port p independently selects the word at `raddr` port p.
  - Out-of-range addresses read 0.
  - Any number of ports may read the same address.
- Bypass (`BYPASS`=1):
  - Applies to a read port when `we`=1, `reset`=0, `raddr` port p equals `waddr`, and the address is not zero-masked.
  - On that port, each byte with `wstrb`=1 comes from `wdata`; the other bytes come from storage.
  - With `BYPASS`=0, a read of the address being written returns the old value.
- Reset priority: `reset` overrides `we`. No write commits and no bypass occurs while `reset`=1.

## Timing
- `OUT_REG`=0:
  - `rdata` is combinational from `raddr`, storage and (when bypassed) `we`/`waddr`/`wstrb`/`wdata`.
  - A write is visible through storage on the cycle after the edge, or in the same cycle via bypass.
  - After the first reset edge, `rdata`=0 for all ports until the first write.
- `OUT_REG`=1:
  - `rdata` is registered. It is sampled at the edge where the read is presented, using the same-cycle bypassed value.
  - Read latency is 1 cycle.
  - `rdata` resets to 0 on an edge with `reset`=1.
- Write latency: 1 edge. Register state changes only on rising `clk`.
- A reset asserted mid-sequence clears everything at that edge. A write presented in the same cycle as reset is lost.

## Structure
- Shared package `mips_pkg` holds:
  - `MIPS_DATA_W`=32, `MIPS_NUM_REGS`=32, `MIPS_REG_ADDR_W`=5, `MIPS_REG_ZERO`=5'd0.
  - typedef `mips_word_t` (logic [31:0]) and typedef `mips_reg_addr_t` (logic [4:0]).
- Sub-module `reg_file_rd_port`:
  - Contents: address decode/mux, zero masking, byte-merge bypass and optional output register.
  - Instantiated `NUM_RD` times by generate loop.
- The write decode and storage array stay in `reg_file`.

## Test plan
- Reset behaviour (defaults): hold `reset`=1 for 2 cycles, then release and read addresses 1..31 on both ports -> `rdata`=0 on every port.
- Full-word write and zero register (defaults):
  - Write 32'd55 to r5 (`wstrb`=4'hF), then read r5 on port 0 next cycle -> 32'h00000037.
  - Write 32'hFFFFFFFF to r0, then read r0 -> 0.
- Byte strobes: r7=32'h11223344, then write 32'hAABBCCDD with `wstrb`=4'b0101 -> next-cycle read of r7 = 32'h11BB33DD.
- Bypass:
  - Same-cycle read of r9 while writing 32'd44 to r9 -> `rdata` port 0 = 32'h0000002C in that cycle.
  - Repeat with `BYPASS`=0 -> old value in that cycle, 32'h2C the next cycle.
- Registered read and reset priority:
  - `OUT_REG`=1: present `raddr` r5 at edge N -> value appears after edge N, not before.
  - Assert `reset` together with a write of 32'd99 to r3 -> r3 reads 0 afterwards and `rdata`=0.
- Multi-port (`NUM_RD`=3, `DATA_W`=16, `NUM_REGS`=12):
  - Ports read r2, r2, r11 after writes of 16'h1234 to r2 and 16'hBEEF to r11 -> 1234/1234/BEEF.
  - A write to address 12 is ignored and reading address 12 returns 0.

Source files
------------

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared MIPS-wide constants and types used by the decode-stage register file
// and any other block that needs to talk about architectural registers.
//   MIPS_DATA_W      : architectural word width
//   MIPS_NUM_REGS    : number of general-purpose registers
//   MIPS_REG_ADDR_W  : register specifier width (rs/rt/rd fields)
//   MIPS_REG_ZERO    : specifier of the hardwired-zero register $zero
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam int MIPS_DATA_W     = 32;
  localparam int MIPS_NUM_REGS   = 32;
  localparam int MIPS_REG_ADDR_W = 5;

  localparam logic [MIPS_REG_ADDR_W-1:0] MIPS_REG_ZERO = 5'd0;

  typedef logic [MIPS_DATA_W-1:0]     mips_word_t;
  typedef logic [MIPS_REG_ADDR_W-1:0] mips_reg_addr_t;

endpackage

// File: rtl/reg_file_rd_port.sv
// ---------------------------------------------------------------------------
// reg_file_rd_port
// One read port of the register file: selects a word from the storage array,
// forces the zero register to read 0, merges in same-cycle write bytes when
// bypass is enabled and optionally registers the result.
// Ports:
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   mem          : whole storage array, word w at mem[w]
//   we/waddr/
//   wstrb/wdata  : the write port, observed for bypass
//   raddr        : word address for this port
//   rdata        : read data (combinational or registered per OUT_REG)
// ---------------------------------------------------------------------------
module reg_file_rd_port import mips_pkg::*; #(
  parameter int DATA_W   = MIPS_DATA_W,
  parameter int NUM_REGS = MIPS_NUM_REGS,
  parameter int ADDR_W   = MIPS_REG_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int OUT_REG  = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]    mem,
  input  logic                               we,
  input  logic [ADDR_W-1:0]                  waddr,
  input  logic [DATA_W/8-1:0]                wstrb,
  input  logic [DATA_W-1:0]                  wdata,
  input  logic [ADDR_W-1:0]                  raddr,
  output logic [DATA_W-1:0]                  rdata
);

  localparam int NUM_BYTES = DATA_W / 8;

  logic              in_range;
  logic              zero_hit;
  logic              bypass_hit;
  logic [DATA_W-1:0] stored;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] read_val;

  // Non-power-of-2 depths leave unused addresses; those read as 0.
  assign in_range = (int'(raddr) < NUM_REGS);
  assign zero_hit = (ZERO_REG != 0) && (raddr == '0);

  // Bypass is suppressed during reset because the write will not commit,
  // and for out-of-range or zero-masked addresses which must read 0.
  assign bypass_hit = (BYPASS != 0) && we && !reset && (raddr == waddr) &&
                      in_range && !zero_hit;

  // Storage lookup
  always_comb begin
    stored = '0;
    if (in_range) begin
      stored = mem[raddr];
    end
  end

  // Byte-wise merge of the in-flight write over the stored word
  always_comb begin
    merged = stored;
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (wstrb[b]) begin
        merged[b*8 +: 8] = wdata[b*8 +: 8];
      end
    end
  end

  // Final port value before the optional output register
  always_comb begin
    read_val = stored;
    if (zero_hit) begin
      read_val = '0;
    end else if (bypass_hit) begin
      read_val = merged;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] rdata_q;

      // Registered read: captures the same-cycle (bypassed) value
      always_ff @(posedge clk) begin
        if (reset) begin
          rdata_q <= '0;
        end else begin
          rdata_q <= read_val;
        end
      end

      assign rdata = rdata_q;
    end else begin : g_comb_out
      logic unused_clk;
      assign unused_clk = ^{1'b0, clk};
      assign rdata      = read_val;
    end
  endgenerate

endmodule

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
// Parametrised multi-port register file for the MIPS decode stage:
// NUM_REGS words of DATA_W bits, one byte-strobed write port (from WB) and
// NUM_RD read ports (rs/rt operands). Optional hardwired-zero word 0,
// optional write-to-read bypass and optional registered read outputs.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset, clears storage and outputs
//   we     : write enable
//   waddr  : write word address
//   wstrb  : byte strobes, bit i covers wdata[8i+7:8i]
//   wdata  : write data
//   raddr  : packed read addresses, port p at [p*ADDR_W +: ADDR_W]
//   rdata  : packed read data, port p at [p*DATA_W +: DATA_W]
// ---------------------------------------------------------------------------
module reg_file import mips_pkg::*; #(
  parameter  int DATA_W   = MIPS_DATA_W,
  parameter  int NUM_REGS = MIPS_NUM_REGS,
  parameter  int NUM_RD   = 2,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  parameter  int OUT_REG  = 0,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W/8-1:0]      wstrb,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata
);

  localparam int NUM_BYTES = DATA_W / 8;

  logic [NUM_REGS-1:0][DATA_W-1:0] mem;
  logic                            write_ok;

  // Out-of-range addresses and (optionally) word 0 never take a write
  assign write_ok = we && (int'(waddr) < NUM_REGS) &&
                    !((ZERO_REG != 0) && (waddr == '0));

  // Storage array: reset clears every word, writes update strobed bytes only
  always_ff @(posedge clk) begin
    if (reset) begin
      mem <= '0;
    end else if (write_ok) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (wstrb[b]) begin
          mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  generate
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      reg_file_rd_port #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS),
        .OUT_REG  (OUT_REG)
      ) u_rd_port (
        .clk   (clk),
        .reset (reset),
        .mem   (mem),
        .we    (we),
        .waddr (waddr),
        .wstrb (wstrb),
        .wdata (wdata),
        .raddr (raddr[p*ADDR_W +: ADDR_W]),
        .rdata (rdata[p*DATA_W +: DATA_W])
      );
    end
  endgenerate

endmodule
